// File: rtl/shift_exu_pkg.sv
// -----------------------------------------------------------------------------
// shift_exu_pkg
//   Shared definitions for the RV64 shift execution unit:
//     - default datapath and tag widths
//     - shift micro-op encodings as issued by the decoder
//     - the S1 (decode register) payload struct
//     - a decode helper that turns an issued op into the S1 payload
// -----------------------------------------------------------------------------
package shift_exu_pkg;

  localparam int SHIFT_XLEN  = 64;
  localparam int SHIFT_TAG_W = 5;
  localparam int SHAMT_W     = 6;

  // Encoding as it arrives on in_op. Bit 2 marks the 32-bit (W) variants;
  // low bits 2'b11 are reserved in both halves.
  typedef enum logic [2:0] {
    SHIFT_SLL  = 3'd0,
    SHIFT_SRL  = 3'd1,
    SHIFT_SRA  = 3'd2,
    SHIFT_SLLW = 3'd4,
    SHIFT_SRLW = 3'd5,
    SHIFT_SRAW = 3'd6
  } shift_op_e;

  // Everything the barrel shifter and the result stage need, latched in S1.
  typedef struct packed {
    logic [SHIFT_XLEN-1:0]  data;   // operand already prepared for the shifter
    logic [SHAMT_W-1:0]     shamt;  // 6-bit amount, bit 5 forced low for W ops
    logic                   lorr;   // 1 = shift left
    logic                   aorl;   // 1 = arithmetic right shift
    logic                   is_w;   // sign-extend result bits [31:0]
    logic                   rsvd;   // reserved encoding, result forced to zero
    logic [SHIFT_TAG_W-1:0] tag;    // destination tag
  } s1_payload_t;

  // Sign-extend the low word of a 64-bit value.
  function automatic logic [SHIFT_XLEN-1:0] sext32(input logic [SHIFT_XLEN-1:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // Build the S1 payload from an issued op. Only src2[5:0] (64-bit ops) or
  // src2[4:0] (W ops) contribute to the shift amount.
  function automatic s1_payload_t decode_op(
    input logic [2:0]             op,
    input logic [SHIFT_XLEN-1:0]  src1,
    input logic [SHIFT_XLEN-1:0]  src2,
    input logic [SHIFT_TAG_W-1:0] tag
  );
    s1_payload_t p;
    p       = '0;
    p.tag   = tag;
    p.is_w  = op[2];
    case (op)
      SHIFT_SLL: begin
        p.data  = src1;
        p.shamt = src2[5:0];
        p.lorr  = 1'b1;
      end
      SHIFT_SRL: begin
        p.data  = src1;
        p.shamt = src2[5:0];
      end
      SHIFT_SRA: begin
        p.data  = src1;
        p.shamt = src2[5:0];
        p.aorl  = 1'b1;
      end
      SHIFT_SLLW: begin
        p.data  = {32'b0, src1[31:0]};
        p.shamt = {1'b0, src2[4:0]};
        p.lorr  = 1'b1;
      end
      // Zero-extending the word keeps bits shifted down from [63:32] zero.
      SHIFT_SRLW: begin
        p.data  = {32'b0, src1[31:0]};
        p.shamt = {1'b0, src2[4:0]};
      end
      // Sign-extending the word makes a 64-bit arithmetic shift give the
      // correct 32-bit arithmetic result in bits [31:0].
      SHIFT_SRAW: begin
        p.data  = sext32(src1);
        p.shamt = {1'b0, src2[4:0]};
        p.aorl  = 1'b1;
      end
      default: begin
        p.rsvd  = 1'b1;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/shift_exu_barrel.sv
// -----------------------------------------------------------------------------
// shift_exu_barrel
//   Existing 64-bit logarithmic barrel shifter, purely combinational.
//   Six layers, layer k shifts by 2**k when i_shamt[k] is set. Left shifts
//   are performed by bit-reversing the operand, shifting right with zero
//   fill and reversing back, so a single right-shift network serves both
//   directions.
//
// Ports
//   i_data    [63:0]  operand
//   i_shamt   [5:0]   shift amount
//   i_lorr            1 = left, 0 = right
//   i_aorl            1 = arithmetic (sign fill) for right shifts
//   o_result  [63:0]  shifted value
// -----------------------------------------------------------------------------
module shift_exu_barrel
  import shift_exu_pkg::*;
(
  input  logic [SHIFT_XLEN-1:0] i_data,
  input  logic [SHAMT_W-1:0]    i_shamt,
  input  logic                  i_lorr,
  input  logic                  i_aorl,
  output logic [SHIFT_XLEN-1:0] o_result
);

  function automatic logic [SHIFT_XLEN-1:0] bit_reverse(input logic [SHIFT_XLEN-1:0] v);
    logic [SHIFT_XLEN-1:0] r;
    for (int i = 0; i < SHIFT_XLEN; i++) begin
      r[i] = v[SHIFT_XLEN-1-i];
    end
    return r;
  endfunction

  logic                  w_fill;
  logic [SHIFT_XLEN-1:0] w_stage;

  always_comb begin
    // NOTE: every variable written here gets a value before any conditional
    // update; leaving one unassigned on some path would infer a latch.
    w_fill  = i_aorl & ~i_lorr & i_data[SHIFT_XLEN-1];
    w_stage = i_lorr ? bit_reverse(i_data) : i_data;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (i_shamt[k]) begin
        // One extra fill bit on top; arithmetic shift replicates it in.
        w_stage = SHIFT_XLEN'($signed({w_fill, w_stage}) >>> (1 << k));
      end
    end
    o_result = i_lorr ? bit_reverse(w_stage) : w_stage;
  end

endmodule

// File: rtl/shift_exu.sv
// -----------------------------------------------------------------------------
// shift_exu
//   Pipelined RV64 shift execution unit (EX stage).
//     S1: decode register - prepared operand, shift amount, controls, tag.
//     S2: result register - barrel-shifter output, W results sign-extended,
//         reserved ops forced to zero.
//   Valid/ready on both sides, one op per cycle, 2-cycle latency when not
//   stalled. flush kills both stages at the next clock edge.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   flush            synchronous kill of all in-flight ops
//   in_valid/ready   issue handshake
//   in_op            micro-op (see shift_op_e), 3 and 7 reserved
//   in_src1/src2     operand / shift-amount source
//   in_tag           destination tag
//   out_valid/ready  writeback handshake
//   out_result/tag   result and its tag, held stable while stalled
// -----------------------------------------------------------------------------
module shift_exu
  import shift_exu_pkg::*;
#(
  // Only the default widths are supported; the S1 payload is sized from the package.
  parameter int XLEN  = SHIFT_XLEN,
  parameter int TAG_W = SHIFT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_s1_valid;
  s1_payload_t      r_s1;
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic [XLEN-1:0]  w_shift_out;
  logic [XLEN-1:0]  w_s2_result_d;

  // S2 can take a new op when empty or when its current op leaves this
  // cycle; S1 moves only into a free S2. in_ready therefore depends
  // combinationally on out_ready.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_adv;
  assign in_ready  = (!r_s1_valid || w_s2_adv) && !flush;
  assign w_in_fire = in_valid && in_ready;

  shift_exu_barrel u_barrel (
    .i_data   (r_s1.data),
    .i_shamt  (r_s1.shamt),
    .i_lorr   (r_s1.lorr),
    .i_aorl   (r_s1.aorl),
    .o_result (w_shift_out)
  );

  assign w_s2_result_d = r_s1.rsvd ? '0 :
                         r_s1.is_w ? sext32(w_shift_out) :
                                     w_shift_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data/tag registers are reset along with the valids so the
      // outputs read as zero during reset, not just invalid.
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; S2 must see the S1 contents from before this edge.
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_in_fire) begin
          r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
          r_s1_valid <= 1'b0;
        end
        if (w_s1_adv) begin
          r_s2_valid <= 1'b1;
        end else if (out_ready) begin
          r_s2_valid <= 1'b0;
        end
      end

      // Data moves with its valid; during a flush it may go stale, which is
      // harmless because the valids are cleared.
      if (w_in_fire) begin
        r_s1 <= decode_op(in_op, in_src1, in_src2, in_tag);
      end
      if (w_s1_adv) begin
        r_s2_result <= w_s2_result_d;
        r_s2_tag    <= r_s1.tag;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;

endmodule

// File: tb/tb_shift_exu.sv
module tb_shift_exu;
  import shift_exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;
  exp_t sb[$];

  shift_exu dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V shift semantics in plain arithmetic.
  function automatic logic [63:0] ref_shift(input logic [2:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    logic [31:0] w;
    case (op)
      3'd0: return a << b[5:0];
      3'd1: return a >> b[5:0];
      3'd2: return $signed(a) >>> b[5:0];
      3'd4: begin w = a[31:0] << b[4:0];          return {{32{w[31]}}, w}; end
      3'd5: begin w = a[31:0] >> b[4:0];          return {{32{w[31]}}, w}; end
      3'd6: begin w = $signed(a[31:0]) >>> b[4:0]; return {{32{w[31]}}, w}; end
      default: return 64'd0;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op into an empty pipeline and check the 2-cycle latency.
  task automatic run_single(input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] tag,
                            input logic [63:0] exp, input string name);
    flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s accept: in_ready=%b expected 1", name, in_ready);
    end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s latency1: out_valid=%b expected 0", name, out_valid);
    end
    next_cycle();
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== exp || out_tag !== tag) begin
      n_err++;
      $display("FAIL %s result: valid=%b result=%h tag=%0d expected valid=1 result=%h tag=%0d",
               name, out_valid, out_result, out_tag, exp, tag);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b result=%h tag=%0d expected 0/0/0",
               out_valid, out_result, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_single(SHIFT_SLL,  64'h1,                   64'h20, 5'd1, 64'h0000_0001_0000_0000, "sll_32");
    run_single(SHIFT_SLL,  64'h1,                   64'h10, 5'd2, 64'h0000_0000_0001_0000, "sll_16");
    run_single(SHIFT_SRA,  64'h8000_0000_0000_0000, 64'h3F, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, "sra_63");
    run_single(SHIFT_SRL,  64'h8000_0000_0000_0000, 64'h3F, 5'd4, 64'h0000_0000_0000_0001, "srl_63");
    run_single(SHIFT_SRAW, 64'hDEAD_0000_8000_0000, 64'h4,  5'd5, 64'hFFFF_FFFF_F800_0000, "sraw_4");
    run_single(SHIFT_SRLW, 64'hDEAD_0000_8000_0000, 64'h4,  5'd6, 64'h0000_0000_0800_0000, "srlw_4");
    run_single(SHIFT_SLLW, 64'h1,                   64'hFF, 5'd7, 64'hFFFF_FFFF_8000_0000, "sllw_31");
    run_single(SHIFT_SLL,  64'h3,                   64'hFFC1, 5'd8, 64'h6,                 "sll_upper_ignored");
    run_single(3'd3,       64'hFFFF,                64'h1,  5'd9, 64'h0,                   "rsvd3");
    run_single(3'd7,       64'hFFFF,                64'h1,  5'd10, 64'h0,                  "rsvd7");
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got  = 1;
    flush = 1'b0; out_ready = 1'b0;
    in_op = SHIFT_SLL; in_src2 = 64'd0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_tag = 5'(sent + 1); in_src1 = 64'(sent + 1);
      #1;
      if (c >= 2) begin
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_result !== 64'd1) begin
          n_err++;
          $display("FAIL bp_stall c=%0d: in_ready=%b valid=%b tag=%0d result=%h expected 0/1/1/1",
                   c, in_ready, out_valid, out_tag, out_result);
        end
      end
      if (in_valid && in_ready) sent++;
      next_cycle();
    end
    n_vec++;
    if (sent != 2) begin
      n_err++; $display("FAIL bp_accepts: accepted %0d expected 2", sent);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got <= 4; c++) begin
      in_valid = (sent < 4); in_tag = 5'(sent + 1); in_src1 = 64'(sent + 1);
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_tag !== 5'(got) || out_result !== 64'(got)) begin
          n_err++;
          $display("FAIL bp_order: tag=%0d result=%h expected tag=%0d result=%h",
                   out_tag, out_result, got, 64'(got));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      next_cycle();
    end
    in_valid = 1'b0;
    n_vec++;
    if (got != 5) begin
      n_err++; $display("FAIL bp_delivered: delivered %0d expected 4", got - 1);
    end
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_no_dup: out_valid=%b expected 0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_op = SHIFT_SLL; in_src1 = 64'h3; in_src2 = 64'h1; in_tag = 5'd10;
    next_cycle();
    in_tag = 5'd11; in_src1 = 64'h5;
    next_cycle();
    // S2 holds tag 10, S1 holds tag 11. Flush with an output handshake.
    in_tag = 5'd12; flush = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_in_ready: in_ready=%b expected 0", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_tag !== 5'd10 || out_result !== 64'h6) begin
      n_err++;
      $display("FAIL flush_delivered: valid=%b tag=%0d result=%h expected 1/10/6",
               out_valid, out_tag, out_result);
    end
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_killed c=%0d: out_valid=%b tag=%0d expected valid 0",
                          c, out_valid, out_tag);
      end
      next_cycle();
    end
    run_single(SHIFT_SRL, 64'hF0, 64'h4, 5'd13, 64'hF, "post_flush");
  endtask

  task automatic test_random(input int n_cycles);
    logic        stalled = 1'b0;
    logic [63:0] held_res = '0;
    logic [4:0]  held_tag = '0;
    logic        acc, del;
    exp_t        e;
    flush = 1'b0;
    sb.delete();
    for (int c = 0; c < n_cycles; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_src1   = {$urandom, $urandom};
      in_src2   = {$urandom, $urandom};
      in_tag    = 5'($urandom);
      #1;
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
          n_err++;
          $display("FAIL rand_hold c=%0d: valid=%b result=%h tag=%0d expected 1/%h/%0d",
                   c, out_valid, out_result, out_tag, held_res, held_tag);
        end
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_extra c=%0d: result=%h tag=%0d with none expected",
                            c, out_result, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL rand_result c=%0d: result=%h tag=%0d expected %h tag=%0d",
                     c, out_result, out_tag, e.res, e.tag);
          end
        end
      end
      if (acc) sb.push_back(exp_t'{ref_shift(in_op, in_src1, in_src2), in_tag});
      stalled  = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL drain_extra: tag=%0d with none expected", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL drain_result: result=%h tag=%0d expected %h tag=%0d",
                     out_result, out_tag, e.res, e.tag);
          end
        end
      end
      next_cycle();
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rand_lost: %0d results never delivered, expected 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_op = SHIFT_SLL; in_src1 = 64'h5; in_src2 = 64'h0; in_tag = 5'd7;
    next_cycle();
    in_tag = 5'd8;
    next_cycle();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b result=%h tag=%0d expected 0/0/0",
               out_valid, out_result, out_tag);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_idle: valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    run_single(SHIFT_SRL, 64'hF0, 64'h4, 5'd14, 64'hF, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random(400);
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_exu.md
Name: shift_exu

Overview:
- Pipelined RV64 shift execution unit in the EX stage.
- Accepts decoded shift micro-ops from issue and forms the operand, shift amount and direction/arithmetic controls for the existing 64-bit barrel shifter.
- Sign-extends W-variant results and returns them with the destination tag to writeback.
- Two register stages, valid/ready on both sides, one op per cycle when not stalled.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 5, width of the destination-register tag carried alongside the op.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; drops all in-flight ops.
- in_valid  in  1  issue presents an op.
- in_ready  out  1  unit accepts the op this cycle.
- in_op  in  3  0=SLL, 1=SRL, 2=SRA, 4=SLLW, 5=SRLW, 6=SRAW; 3 and 7 reserved.
- in_src1  in  XLEN  value to shift.
- in_src2  in  XLEN  shift-amount source (rs2 or immediate); only low bits are used.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result is valid.
- out_ready  in  1  writeback accepts the result.
- out_result  out  XLEN  shift result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst=1), effective immediately with no clock edge: S1/S2 valid=0, all data/tag registers=0, so out_valid=0, out_result=0, out_tag=0.
- Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- out_valid/out_result/out_tag stay stable while out_valid&&!out_ready.
- Stage S1 (decode register) captures:
  - SLL/SRL/SRA: data=src1, shamt=src2[5:0].
  - SLLW/SRLW: data={32'b0, src1[31:0]}, shamt={1'b0, src2[4:0]}.
  - SRAW: data=sign-extension of src1[31:0], shamt={1'b0, src2[4:0]}.
  - LorR=1 for left ops; AorL=1 for SRA/SRAW.
  - is_w flag and reserved flag.
- Stage S2 (result register) captures the barrel-shifter output:
  - W ops: result = sign-extension of shifter bits [31:0].
  - Reserved op: result=0, op still completes normally.
- Latency: 2 cycles from input handshake to out_valid under no stall.
- Throughput: 1 op/cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = (!s1_valid || s2_adv) && !flush. This is a combinational path from out_ready and is permitted.
- Full: with both stages valid and out_ready=0, in_ready=0 and nothing moves.
- Ordering: results leave in issue order. No loss, no duplication.
- Flush: at the next edge, s1_valid=0 and s2_valid=0; in_valid is ignored in the flush cycle; data registers may hold stale values.
  - Flush coincident with an output handshake: that result counts as delivered.
- Shift amounts: 6 bits for 64-bit ops, 5 bits for W ops. Upper src2 bits are ignored.
- All six shifter layers must honour their own shamt bit; shamt=32 must differ from shamt=16.

Decomposition:
- Shared package holds:
  - op encodings SHIFT_SLL/SRL/SRA/SLLW/SRLW/SRAW;
  - XLEN and TAG_W defaults;
  - the S1 payload struct {data, shamt, LorR, AorL, is_w, rsvd, tag}.
- One sub-module: the existing 64-bit barrel shifter, instantiated once, combinationally between S1 and S2. All shifting happens there; this unit adds no shift logic of its own.

Test Plan:
- SLL, src1=0x1, src2=0x20 -> out_result=0x0000_0001_0000_0000, out_valid 2 cycles after accept. Catches a shamt[5] layer miswire.
- SRA, src1=0x8000_0000_0000_0000, src2=0x3F -> 0xFFFF_FFFF_FFFF_FFFF. SRL with the same operands -> 0x1.
- W ops with src2=4:
  - SRAW, src1=0xDEAD_0000_8000_0000 -> 0xFFFF_FFFF_F800_0000.
  - SRLW, same src1 -> 0x0000_0000_0800_0000.
  - SLLW, src1=0x1, src2=0xFF (shamt=31) -> 0xFFFF_FFFF_8000_0000.
- Backpressure: issue 4 back-to-back ops with tags 1..4 while out_ready=0 for 5 cycles -> in_ready drops after 2 accepts. Release -> tags 1,2,3,4 delivered in order, each exactly once, with held values stable during the stall.
- Flush with 2 ops in flight -> out_valid=0 next cycle. The next op issued (SRL 0xF0>>4) returns 0xF with no stale data.
- Async reset asserted mid-stream between clock edges -> out_valid and in-flight state cleared immediately. After release, the first op completes with 2-cycle latency.
